// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// | Module   : fetch_unit_pkg                                                 |
// | Purpose  : Shared types and constants for the instruction fetch stage.    |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_REQ   = 3'd1,
    F_LATCH = 3'd2,
    F_READY = 3'd3,
    F_DONE  = 3'd4
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
// ============================================================================
// | Module   : branch_lut                                                     |
// | Purpose  : Register-array branch target table, one write port and one     |
// |            combinational read port. Only built when BRANCH_LUT_EN is set. |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

`ifdef BRANCH_LUT_EN
module branch_lut #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddr,
  output logic [DATA_W-1:0] readData
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_table [c_DEPTH];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (writeEn) begin
      r_table[writeAddr] <= writeData;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old entry.
  assign readData = r_table[readAddr];

endmodule
`endif

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// | Module   : fetch_unit                                                     |
// | Purpose  : PC / IR owner feeding the multi-cycle control FSM. Optional    |
// |            table-driven branch targets via macro BRANCH_LUT_EN.           |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 BR_W       = 5,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                start,
  input  logic                nextIns,
  input  logic                branchTaken,
  input  logic [BR_W-1:0]     branchField,
`ifdef BRANCH_LUT_EN
  input  logic                lutWe,
  input  logic [BR_W-1:0]     lutAddr,
  input  logic [PC_W-1:0]     lutData,
`endif
  output logic [PC_W-1:0]     imemAddr,
  input  logic [INSTR_W-1:0]  imemData,
  output logic [INSTR_W-1:0]  instruction,
  output logic [OPCODE_W-1:0] opcode,
  output logic                insValid,
  output logic [PC_W-1:0]     pc,
  output logic                done
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_insValid;
  logic               r_done;

  logic [PC_W-1:0]    w_target;
  logic [PC_W-1:0]    w_nextPc;
  logic               w_pcAtEnd;
  logic               w_isHalt;

`ifdef BRANCH_LUT_EN
  branch_lut #(
    .ADDR_W (BR_W),
    .DATA_W (PC_W)
  ) u_branchLut (
    .clock     (clock),
    .resetN    (resetN),
    .writeEn   (lutWe),
    .writeAddr (lutAddr),
    .writeData (lutData),
    .readAddr  (branchField),
    .readData  (w_target)
  );
`else
  // PC-relative: sign-extended offset, wrapping modulo the PC range.
  assign w_target = r_pc + PC_W'($signed(branchField));
`endif

  assign w_nextPc  = branchTaken ? w_target : r_pc + PC_W'(1);
  assign w_pcAtEnd = (r_pc == {PC_W{1'b1}});
  assign w_isHalt  = (r_ir == HALT_INSTR);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= F_IDLE;
      r_pc       <= START_ADDR;
      r_ir       <= '0;
      r_insValid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (start) begin
            r_state <= F_REQ;
            r_pc    <= START_ADDR;
          end
        end
        F_REQ: begin
          r_state <= F_LATCH;
        end
        F_LATCH: begin
          r_ir       <= imemData;
          r_insValid <= 1'b1;
          r_state    <= F_READY;
        end
        F_READY: begin
          if (nextIns) begin
            r_insValid <= 1'b0;
            // Halt or sequential step past the last address ends the program.
            if (w_isHalt || (!branchTaken && w_pcAtEnd)) begin
              r_state <= F_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= F_REQ;
              r_pc    <= w_nextPc;
            end
          end
        end
        F_DONE: begin
          if (start) begin
            r_state <= F_REQ;
            r_pc    <= START_ADDR;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= F_IDLE;
        end
      endcase
    end
  end

  assign imemAddr    = r_pc;
  assign pc          = r_pc;
  assign instruction = r_ir;
  assign opcode      = r_ir[INSTR_W-1 -: OPCODE_W];
  assign insValid    = r_insValid;
  assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// | Module   : tb_fetch_unit                                                  |
// | Purpose  : Directed self-checking bench for fetch_unit (BRANCH_LUT_EN     |
// |            adds the table-target scenario).                               |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int BR_W    = 5;

  logic               clock = 1'b0;
  logic               resetN;
  logic               start;
  logic               nextIns;
  logic               branchTaken;
  logic [BR_W-1:0]    branchField;
  logic [PC_W-1:0]    imemAddr;
  logic [INSTR_W-1:0] imemData;
  logic [INSTR_W-1:0] instruction;
  logic [2:0]         opcode;
  logic               insValid;
  logic [PC_W-1:0]    pc;
  logic               done;
`ifdef BRANCH_LUT_EN
  logic               lutWe;
  logic [BR_W-1:0]    lutAddr;
  logic [PC_W-1:0]    lutData;
`endif

  logic [INSTR_W-1:0] rom [1024];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) imemData <= rom[imemAddr];

  fetch_unit u_dut (
    .clock       (clock),
    .resetN      (resetN),
    .start       (start),
    .nextIns     (nextIns),
    .branchTaken (branchTaken),
    .branchField (branchField),
`ifdef BRANCH_LUT_EN
    .lutWe       (lutWe),
    .lutAddr     (lutAddr),
    .lutData     (lutData),
`endif
    .imemAddr    (imemAddr),
    .imemData    (imemData),
    .instruction (instruction),
    .opcode      (opcode),
    .insValid    (insValid),
    .pc          (pc),
    .done        (done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (insValid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    total++;
    if (insValid !== 1'b1) begin bad++; $display("FAIL %s: insValid never rose, got %b want 1", name, insValid); end
  endtask

  task automatic retire(input logic bt, input logic [BR_W-1:0] bf);
    nextIns = 1'b1; branchTaken = bt; branchField = bf;
    step();
    nextIns = 1'b0; branchTaken = 1'b0; branchField = '0;
  endtask

  task automatic test_reset();
    total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    total++; if (insValid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags: got v=%b d=%b want 0 0", insValid, done); end
    total++; if (instruction !== 9'h000) begin bad++; $display("FAIL reset_ir: got %h want 000", instruction); end
    nextIns = 1'b1; step(); step(); nextIns = 1'b0; step(); step();
    total++; if (insValid !== 1'b0 || pc !== 10'd0) begin bad++; $display("FAIL idle_nextins: got v=%b pc=%0d want 0 0", insValid, pc); end
    start = 1'b1; step(); start = 1'b0;
    wait_valid("reset_first_fetch");
    retire(1'b1, 5'd8);
    step();  // now in LATCH with pc=8
    total++; if (pc !== 10'd8 || insValid !== 1'b0) begin bad++; $display("FAIL pre_reset_pc: got %0d want 8", pc); end
    resetN = 1'b0; #1;
    total++; if (pc !== 10'd0 || insValid !== 1'b0 || instruction !== 9'h000 || done !== 1'b0) begin
      bad++; $display("FAIL async_reset: got pc=%0d v=%b ir=%h d=%b want 0 0 000 0", pc, insValid, instruction, done); end
    step();
    resetN = 1'b1;
    step(); step(); step();
    total++; if (insValid !== 1'b0 || instruction !== 9'h000 || pc !== 10'd0) begin
      bad++; $display("FAIL post_reset_idle: got v=%b ir=%h pc=%0d want 0 000 0", insValid, instruction, pc); end
  endtask

  task automatic test_program();
    start = 1'b1; step(); start = 1'b0;
    step();
    total++; if (insValid !== 1'b0) begin bad++; $display("FAIL start_latency_early: got %b want 0", insValid); end
    step();
    total++; if (insValid !== 1'b1 || opcode !== 3'b001 || instruction !== 9'h041) begin
      bad++; $display("FAIL prog_op0: got v=%b op=%b ir=%h want 1 001 041", insValid, opcode, instruction); end
    retire(1'b0, '0);
    total++; if (pc !== 10'd1 || insValid !== 1'b0) begin bad++; $display("FAIL prog_pc1: got pc=%0d v=%b want 1 0", pc, insValid); end
    wait_valid("prog_op1_valid");
    total++; if (opcode !== 3'b010) begin bad++; $display("FAIL prog_op1: got %b want 010", opcode); end
    retire(1'b0, '0);
    wait_valid("prog_op2_valid");
    total++; if (opcode !== 3'b111 || pc !== 10'd2) begin bad++; $display("FAIL prog_op2: got op=%b pc=%0d want 111 2", opcode, pc); end
    retire(1'b0, '0);
    total++; if (done !== 1'b1 || pc !== 10'd2 || insValid !== 1'b0) begin
      bad++; $display("FAIL prog_halt: got d=%b pc=%0d v=%b want 1 2 0", done, pc, insValid); end
  endtask

  task automatic test_ignored();
    nextIns = 1'b1; step(); step(); nextIns = 1'b0; step();
    total++; if (done !== 1'b1 || pc !== 10'd2 || insValid !== 1'b0) begin
      bad++; $display("FAIL done_nextins: got d=%b pc=%0d v=%b want 1 2 0", done, pc, insValid); end
    start = 1'b1; nextIns = 1'b1; step(); start = 1'b0; nextIns = 1'b0;
    total++; if (done !== 1'b0 || pc !== 10'd0) begin bad++; $display("FAIL restart: got d=%b pc=%0d want 0 0", done, pc); end
    wait_valid("restart_valid");
    start = 1'b1; branchTaken = 1'b1; branchField = 5'd7; step(); step();
    start = 1'b0; branchTaken = 1'b0; branchField = '0;
    total++; if (pc !== 10'd0 || insValid !== 1'b1 || instruction !== 9'h041) begin
      bad++; $display("FAIL ready_ignores: got pc=%0d v=%b ir=%h want 0 1 041", pc, insValid, instruction); end
  endtask

  task automatic test_relative();
    retire(1'b1, 5'd8);
    total++; if (pc !== 10'd8) begin bad++; $display("FAIL rel_fwd: got %0d want 8", pc); end
    wait_valid("rel_fwd_valid");
    retire(1'b1, 5'b11101);
    total++; if (pc !== 10'd5 || imemAddr !== 10'd5) begin bad++; $display("FAIL rel_back: got pc=%0d addr=%0d want 5 5", pc, imemAddr); end
    wait_valid("rel_back_valid");
    retire(1'b1, 5'b10111);
    total++; if (pc !== 10'd1020) begin bad++; $display("FAIL rel_wrap_down: got %0d want 1020", pc); end
    wait_valid("rel_1020_valid");
    retire(1'b1, 5'b01111);
    total++; if (pc !== 10'd11 || done !== 1'b0) begin bad++; $display("FAIL rel_wrap_up: got pc=%0d d=%b want 11 0", pc, done); end
    wait_valid("rel_11_valid");
  endtask

  task automatic test_hold_nextins();
    nextIns = 1'b1;
    step();
    total++; if (pc !== 10'd12 || insValid !== 1'b0) begin bad++; $display("FAIL hold_first: got pc=%0d v=%b want 12 0", pc, insValid); end
    step(); step();
    total++; if (pc !== 10'd12 || insValid !== 1'b1) begin bad++; $display("FAIL hold_through: got pc=%0d v=%b want 12 1", pc, insValid); end
    nextIns = 1'b0;
    step(); step();
    total++; if (pc !== 10'd12 || insValid !== 1'b1) begin bad++; $display("FAIL hold_single: got pc=%0d v=%b want 12 1", pc, insValid); end
  endtask

  task automatic test_overflow();
    retire(1'b1, 5'b10011);
    total++; if (pc !== 10'd1023) begin bad++; $display("FAIL ovf_setup: got %0d want 1023", pc); end
    wait_valid("ovf_valid");
    retire(1'b0, '0);
    total++; if (done !== 1'b1 || pc !== 10'd1023 || imemAddr !== 10'd1023 || insValid !== 1'b0) begin
      bad++; $display("FAIL ovf_done: got d=%b pc=%0d v=%b want 1 1023 0", done, pc, insValid); end
    start = 1'b1; step(); start = 1'b0;
    total++; if (pc !== 10'd0 || done !== 1'b0 || insValid !== 1'b0) begin
      bad++; $display("FAIL ovf_restart: got pc=%0d d=%b v=%b want 0 0 0", pc, done, insValid); end
    step();
    total++; if (insValid !== 1'b0) begin bad++; $display("FAIL ovf_latency_early: got %b want 0", insValid); end
    step();
    total++; if (insValid !== 1'b1 || opcode !== 3'b001) begin bad++; $display("FAIL ovf_latency: got v=%b op=%b want 1 001", insValid, opcode); end
  endtask

`ifdef BRANCH_LUT_EN
  task automatic test_lut();
    lutWe = 1'b1; lutAddr = 5'd3; lutData = 10'h200; step(); lutWe = 1'b0;
    retire(1'b1, 5'd3);
    total++; if (pc !== 10'h200) begin bad++; $display("FAIL lut_target: got %h want 200", pc); end
    wait_valid("lut_valid");
    lutWe = 1'b1; lutAddr = 5'd3; lutData = 10'h155;
    retire(1'b1, 5'd3);
    lutWe = 1'b0;
    total++; if (pc !== 10'h200) begin bad++; $display("FAIL lut_old_value: got %h want 200", pc); end
    wait_valid("lut_valid2");
    retire(1'b1, 5'd3);
    total++; if (pc !== 10'h155) begin bad++; $display("FAIL lut_new_value: got %h want 155", pc); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h0C3;
    rom[0] = 9'h041; rom[1] = 9'h082; rom[2] = 9'h1FF;
    resetN = 1'b0; start = 1'b0; nextIns = 1'b0; branchTaken = 1'b0; branchField = '0;
`ifdef BRANCH_LUT_EN
    lutWe = 1'b0; lutAddr = '0; lutData = '0;
`endif
    step(); step();
    resetN = 1'b1;
    step();
    test_reset();
    test_program();
    test_ignored();
    test_relative();
    test_hold_nextins();
    test_overflow();
`ifdef BRANCH_LUT_EN
    test_lut();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
